// File: rtl/memory_responder.sv
// memory_responder: accepts one CPU bus transfer at a time, forwards it to an
// external memory with a req/ack handshake and returns read data with a
// one-cycle ready pulse.
// Optional feature: define RESP_TIMEOUT_EN to compile in a watchdog that ends
// a transfer with an error pulse after TIMEOUT_CYCLES REQ cycles without ack.
module memory_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_valid,
    input  logic [15:0] address,
    input  logic        read_write,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        ready,
    output logic        error,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic [1:0]  fsm
);

    if ((TIMEOUT_CYCLES < 32'd1) || (TIMEOUT_CYCLES > 32'd255)) begin : g_bad_timeout
        $error("memory_responder: TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        mem_req_q;
    logic        ready_q;
    logic        timeout_s;

    // Next-state and datapath decode for the IDLE/REQ/DONE handshake.
    always_comb begin
        state_d     = state_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        data_out_d  = data_out_q;
        case (state_q)
            IDLE: begin
                if (bus_valid) begin
                    state_d     = REQ;
                    mem_we_d    = read_write;
                    mem_addr_d  = address;
                    mem_wdata_d = data_in;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    // A real ack always wins over a coincident timeout.
                    state_d = DONE;
                    if (!mem_we_q) begin
                        data_out_d = mem_rdata;
                    end else begin
                        data_out_d = data_out_q;
                    end
                end else if (timeout_s) begin
                    state_d = DONE;
                    if (!mem_we_q) begin
                        data_out_d = 8'hFF;
                    end else begin
                        data_out_d = data_out_q;
                    end
                end else begin
                    state_d = REQ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, request and output registers; async reset clears mem_req at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 8'h00;
            data_out_q  <= 8'h00;
            mem_req_q   <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            data_out_q  <= data_out_d;
            mem_req_q   <= (state_d == REQ);
            ready_q     <= (state_d == DONE);
        end
    end

`ifdef RESP_TIMEOUT_EN
    localparam logic [7:0] TERMINAL_CNT = 8'(TIMEOUT_CYCLES - 32'd1);

    logic [7:0] cnt_q, cnt_d;
    logic       error_q;

    assign timeout_s = (state_q == REQ) && !mem_ack && (cnt_q == TERMINAL_CNT);

    // Watchdog counter: cleared on REQ entry, counts REQ cycles without ack.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == IDLE) && bus_valid) begin
            cnt_d = 8'd0;
        end else if ((state_q == REQ) && !mem_ack && !timeout_s) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Watchdog registers; error is raised for the DONE cycle of a timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= 8'd0;
            error_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            error_q <= timeout_s;
        end
    end

    assign error = error_q;
`else
    assign timeout_s = 1'b0;
    assign error     = 1'b0;
`endif

    assign data_out  = data_out_q;
    assign ready     = ready_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign fsm       = state_q;

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder: the stimulus pushes the expected
// memory request and CPU response; a monitor on the falling edge compares
// whatever the DUT presents against the queue heads.
module tb_memory_responder;

    localparam int TO = 15;

    logic        clk;
    logic        rst;
    logic        bus_valid;
    logic [15:0] address;
    logic        read_write;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        ready;
    logic        error;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic [1:0]  fsm;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } req_t;

    typedef struct packed {
        logic [7:0] dout;
        logic       err;
    } rsp_t;

    req_t       exp_req_q[$];
    rsp_t       exp_rsp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc   = 0;
    logic [7:0] model_dout;

    memory_responder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus_valid  (bus_valid),
        .address    (address),
        .read_write (read_write),
        .data_in    (data_in),
        .data_out   (data_out),
        .ready      (ready),
        .error      (error),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .fsm        (fsm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used for ready-to-ready spacing.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the memory side while mem_req is up and the CPU side on ready.
    always @(negedge clk) begin
        rsp_t rsp;
        if (mem_req) begin
            if (exp_req_q.size() == 0) begin
                check("mem_req_when_none_expected", {31'd0, mem_req}, 32'd0);
            end else begin
                check("mem_we",    {31'd0, mem_we},    {31'd0, exp_req_q[0].we});
                check("mem_addr",  {16'd0, mem_addr},  {16'd0, exp_req_q[0].addr});
                check("mem_wdata", {24'd0, mem_wdata}, {24'd0, exp_req_q[0].wdata});
            end
        end
        if (ready) begin
            if (exp_rsp_q.size() == 0) begin
                check("ready_when_none_expected", {31'd0, ready}, 32'd0);
            end else begin
                rsp = exp_rsp_q.pop_front();
                check("data_out", {24'd0, data_out}, {24'd0, rsp.dout});
                check("error",    {31'd0, error},    {31'd0, rsp.err});
                if (exp_req_q.size() != 0) void'(exp_req_q.pop_front());
            end
        end else begin
            check("error_outside_done", {31'd0, error}, 32'd0);
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
    endtask

    // One transfer: request in IDLE, ack after ack_delay plain REQ cycles, or
    // none at all when a timeout is expected. Returns in the DONE cycle.
    task automatic xfer(input logic we, input logic [15:0] addr, input logic [7:0] wdata,
                        input int ack_delay, input logic [7:0] rdata,
                        input logic exp_err, input logic stray);
        req_t r;
        rsp_t s;
        int   n_wait;
        @(posedge clk); #1;
        check("fsm_idle", {30'd0, fsm}, 32'd0);
        bus_valid  = 1'b1;
        read_write = we;
        address    = addr;
        data_in    = wdata;
        r.we    = we;
        r.addr  = addr;
        r.wdata = wdata;
        exp_req_q.push_back(r);
        s.err  = exp_err;
        if (we)           s.dout = model_dout;
        else if (exp_err) s.dout = 8'hFF;
        else              s.dout = rdata;
        model_dout = s.dout;
        exp_rsp_q.push_back(s);
        @(posedge clk); #1;
        bus_valid = 1'b0;
        check("fsm_req",     {30'd0, fsm},     32'd1);
        check("mem_req_rise", {31'd0, mem_req}, 32'd1);
        if (stray) begin
            bus_valid  = 1'b1;
            address    = ~addr;
            read_write = ~we;
            data_in    = ~wdata;
        end
        n_wait = exp_err ? TO - 1 : ack_delay;
        for (int k = 0; k < n_wait; k++) begin
            @(posedge clk); #1;
            check("ready_low_in_req", {31'd0, ready}, 32'd0);
        end
        if (!exp_err) begin
            mem_ack   = 1'b1;
            mem_rdata = rdata;
        end
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_rdata = 8'hEE;
        bus_valid = 1'b0;
        check("ready_pulse",  {31'd0, ready},   32'd1);
        check("fsm_done",     {30'd0, fsm},     32'd2);
        check("mem_req_fall", {31'd0, mem_req}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t1;
        rst        = 1'b0;
        bus_valid  = 1'b1;
        address    = 16'hFFFF;
        read_write = 1'b1;
        data_in    = 8'hAA;
        mem_rdata  = 8'hEE;
        mem_ack    = 1'b1;
        model_dout = 8'h00;

        // Reset held with active inputs: every output at its reset value.
        idle(3);
        @(negedge clk);
        check("rst_mem_req",   {31'd0, mem_req},   32'd0);
        check("rst_mem_we",    {31'd0, mem_we},    32'd0);
        check("rst_mem_addr",  {16'd0, mem_addr},  32'd0);
        check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        check("rst_data_out",  {24'd0, data_out},  32'd0);
        check("rst_ready",     {31'd0, ready},     32'd0);
        check("rst_error",     {31'd0, error},     32'd0);
        check("rst_fsm",       {30'd0, fsm},       32'd0);
        bus_valid = 1'b0;
        mem_ack   = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;

        // Read with immediate ack.
        xfer(1'b0, 16'h00A5, 8'h00, 0, 8'h3C, 1'b0, 1'b0);
        idle(2);
        // Write with slow ack: data_out must keep 8'h3C.
        xfer(1'b1, 16'h1234, 8'h7E, 4, 8'h55, 1'b0, 1'b0);
        idle(2);

        // Back-to-back read then write, stray bus_valid during REQ.
        xfer(1'b0, 16'h0010, 8'h00, 0, 8'h5A, 1'b0, 1'b1);
        t1 = cyc;
        xfer(1'b1, 16'h0011, 8'h99, 0, 8'h66, 1'b0, 1'b1);
        check("b2b_ready_spacing", 32'(cyc - t1), 32'd3);
        idle(2);

        // Reset in the second REQ cycle, then a late ack for the aborted transfer.
        @(posedge clk); #1;
        bus_valid  = 1'b1;
        read_write = 1'b0;
        address    = 16'hBEEF;
        begin
            req_t r;
            r.we = 1'b0; r.addr = 16'hBEEF; r.wdata = data_in;
            exp_req_q.push_back(r);
        end
        @(posedge clk); #1;
        bus_valid = 1'b0;
        @(posedge clk); #1;
        check("midrst_mem_req_before", {31'd0, mem_req}, 32'd1);
        exp_req_q.delete();
        exp_rsp_q.delete();
        rst = 1'b0;
        #1;
        check("midrst_mem_req_async", {31'd0, mem_req},  32'd0);
        check("midrst_fsm",           {30'd0, fsm},      32'd0);
        check("midrst_data_out",      {24'd0, data_out}, 32'd0);
        model_dout = 8'h00;
        @(posedge clk); #1;
        rst       = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 8'h77;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("late_ack_no_ready",    {31'd0, ready},    32'd0);
            check("late_ack_data_out",    {24'd0, data_out}, 32'd0);
        end
        mem_ack   = 1'b0;
        mem_rdata = 8'hEE;
        idle(2);

`ifdef RESP_TIMEOUT_EN
        // Read with no ack: terminates after TO REQ cycles with error and 8'hFF.
        xfer(1'b0, 16'h4000, 8'h00, 0, 8'h00, 1'b1, 1'b0);
        idle(2);
        // Ack on the terminal REQ cycle wins over the timeout.
        xfer(1'b0, 16'h4001, 8'h00, TO - 1, 8'h81, 1'b0, 1'b0);
        idle(2);
        // Write timeout keeps data_out.
        xfer(1'b1, 16'h4002, 8'h24, 0, 8'h00, 1'b1, 1'b0);
`else
        // No watchdog: REQ waits well past TO cycles for a late ack.
        xfer(1'b0, 16'h4000, 8'h00, 20, 8'hC3, 1'b0, 1'b0);
`endif
        idle(3);
        check("queues_drained", 32'(exp_rsp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
